// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_loader
// Description : Encodes field-level requests into RV32I words and streams
//               them sequentially into instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [2:0]        req_kind,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [20:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              overflow,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [6:0] c_op_r    = 7'b0110011;
    localparam logic [6:0] c_op_i    = 7'b0010011;
    localparam logic [6:0] c_op_lw   = 7'b0000011;
    localparam logic [6:0] c_op_sw   = 7'b0100011;
    localparam logic [6:0] c_op_br   = 7'b1100011;
    localparam logic [6:0] c_op_jal  = 7'b1101111;
    localparam logic [6:0] c_op_jalr = 7'b1100111;

    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              w_fit12;
    logic              w_fit13;
    logic              w_ok;
    logic [31:0]       w_word;
    logic [6:0]        w_hi7;
    logic              w_xfer;
    logic              w_write;
    logic              w_full;

    assign w_fit12 = (&req_imm[20:11]) | ~(|req_imm[20:11]);
    assign w_fit13 = (&req_imm[20:12]) | ~(|req_imm[20:12]);
    assign w_hi7   = req_alt ? 7'b0100000 : 7'b0000000;

    always_comb begin
        w_ok   = 1'b0;
        w_word = 32'd0;
        case (req_kind)
            3'd0: begin
                w_ok   = 1'b1;
                w_word = {w_hi7, req_rs2, req_rs1, req_funct3, req_rd, c_op_r};
            end
            3'd1: begin
                w_ok = w_fit12;
                // Shift immediates carry the arithmetic/logical select in the top bits
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101)
                    w_word = {w_hi7, req_imm[4:0], req_rs1, req_funct3, req_rd, c_op_i};
                else
                    w_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, c_op_i};
            end
            3'd2: begin
                w_ok   = w_fit12;
                w_word = {req_imm[11:0], req_rs1, 3'b010, req_rd, c_op_lw};
            end
            3'd3: begin
                w_ok   = w_fit12;
                w_word = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], c_op_sw};
            end
            3'd4: begin
                w_ok   = w_fit13 && !req_imm[0] && (req_funct3[2:1] != 2'b01);
                w_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                          req_imm[4:1], req_imm[11], c_op_br};
            end
            3'd5: begin
                w_ok   = !req_imm[0];
                w_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                          req_rd, c_op_jal};
            end
            3'd6: begin
                w_ok   = w_fit12;
                w_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, c_op_jalr};
            end
            default: begin
                w_ok   = 1'b0;
                w_word = 32'd0;
            end
        endcase
    end

    assign req_ready = (r_state == c_load);
    assign busy      = (r_state == c_load);
    assign done      = (r_state == c_done);
    assign w_xfer    = req_valid && (r_state == c_load);
    assign w_write   = w_xfer && w_ok;
    assign w_full    = (r_addr == c_last_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_idle;
            r_addr        <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= 32'd0;
            err           <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
        end else begin
            imem_we <= w_write;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_state       <= c_load;
                        r_addr        <= '0;
                        words_written <= '0;
                        err           <= 1'b0;
                        overflow      <= 1'b0;
                    end
                end
                c_load: begin
                    if (w_xfer) begin
                        if (w_write) begin
                            imem_addr     <= r_addr;
                            imem_wdata    <= w_word;
                            words_written <= words_written + (ADDR_W+1)'(1);
                            // Saturate on the last word so the address never wraps
                            if (!w_full)
                                r_addr <= r_addr + ADDR_W'(1);
                        end else begin
                            err <= 1'b1;
                        end
                        if (req_last) begin
                            r_state <= c_done;
                        end else if (w_write && w_full) begin
                            overflow <= 1'b1;
                            r_state  <= c_done;
                        end
                    end
                end
                c_done:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder_loader
// Description : Directed-vector bench for instr_encoder_loader (two sizes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_m_start = 1'b0;
    logic        r_s_start = 1'b0;
    logic        r_valid = 1'b0;
    logic        r_last = 1'b0;
    logic [2:0]  r_kind = 3'd0;
    logic [2:0]  r_f3 = 3'd0;
    logic        r_alt = 1'b0;
    logic [4:0]  r_rd = 5'd0;
    logic [4:0]  r_rs1 = 5'd0;
    logic [4:0]  r_rs2 = 5'd0;
    logic [20:0] r_imm = 21'd0;
    logic        r_sel = 1'b0;

    logic        m_ready, m_we, m_busy, m_done, m_err, m_ovf;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [8:0]  m_ww;
    logic        s_ready, s_we, s_busy, s_done, s_err, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_ww;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8)) u_main (
        .clk(clk), .reset(rst), .start(r_m_start), .req_valid(r_valid),
        .req_ready(m_ready), .req_last(r_last), .req_kind(r_kind),
        .req_funct3(r_f3), .req_alt(r_alt), .req_rd(r_rd), .req_rs1(r_rs1),
        .req_rs2(r_rs2), .req_imm(r_imm), .imem_we(m_we), .imem_addr(m_addr),
        .imem_wdata(m_wdata), .busy(m_busy), .done(m_done), .err(m_err),
        .overflow(m_ovf), .words_written(m_ww)
    );

    instr_encoder_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .reset(rst), .start(r_s_start), .req_valid(r_valid),
        .req_ready(s_ready), .req_last(r_last), .req_kind(r_kind),
        .req_funct3(r_f3), .req_alt(r_alt), .req_rd(r_rd), .req_rs1(r_rs1),
        .req_rs2(r_rs2), .req_imm(r_imm), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .busy(s_busy), .done(s_done), .err(s_err),
        .overflow(s_ovf), .words_written(s_ww)
    );

    logic        w_ready, w_we, w_busy, w_done, w_err, w_ovf;
    logic [7:0]  w_addr;
    logic [31:0] w_wdata;
    logic [8:0]  w_ww;

    assign w_ready = r_sel ? s_ready : m_ready;
    assign w_we    = r_sel ? s_we    : m_we;
    assign w_busy  = r_sel ? s_busy  : m_busy;
    assign w_done  = r_sel ? s_done  : m_done;
    assign w_err   = r_sel ? s_err   : m_err;
    assign w_ovf   = r_sel ? s_ovf   : m_ovf;
    assign w_addr  = r_sel ? {6'd0, s_addr} : m_addr;
    assign w_wdata = r_sel ? s_wdata : m_wdata;
    assign w_ww    = r_sel ? {6'd0, s_ww} : m_ww;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input string tag);
        if (r_sel) r_s_start = 1'b1; else r_m_start = 1'b1;
        step();
        r_s_start = 1'b0;
        r_m_start = 1'b0;
        chk({tag, ".busy"}, w_busy, 1);
        chk({tag, ".ready"}, w_ready, 1);
        chk({tag, ".ww"}, w_ww, 0);
        chk({tag, ".err"}, w_err, 0);
        chk({tag, ".ovf"}, w_ovf, 0);
    endtask

    task automatic xfer(input string tag, input logic [2:0] kind, input logic [2:0] f3,
                        input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [20:0] imm, input logic last,
                        input logic exp_we, input logic [7:0] exp_addr,
                        input logic [31:0] exp_data);
        r_valid = 1'b1;
        r_kind = kind; r_f3 = f3; r_alt = alt; r_rd = rd;
        r_rs1 = rs1; r_rs2 = rs2; r_imm = imm; r_last = last;
        chk({tag, ".rdy"}, w_ready, 1);
        step();
        chk({tag, ".we"}, w_we, exp_we);
        if (exp_we) begin
            chk({tag, ".addr"}, w_addr, exp_addr);
            chk({tag, ".data"}, w_wdata, exp_data);
        end
    endtask

    task automatic idle();
        r_valid = 1'b0;
        r_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst.we", m_we, 0);
        chk("rst.addr", m_addr, 0);
        chk("rst.data", m_wdata, 0);
        chk("rst.busy", m_busy, 0);
        chk("rst.done", m_done, 0);
        chk("rst.err", m_err, 0);
        chk("rst.ovf", m_ovf, 0);
        chk("rst.ready", m_ready, 0);
        chk("rst.ww", m_ww, 0);
        rst = 1'b0;
        step();

        // add / sub, second one closes the session
        start_session("sa");
        xfer("add", 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 8'd0, 32'h002081B3);
        xfer("sub", 3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 8'd1, 32'h402081B3);
        idle();
        chk("sa.done", w_done, 1);
        chk("sa.rdy0", w_ready, 0);
        chk("sa.ww", w_ww, 2);
        step();
        chk("sa.done1", w_done, 0);
        chk("sa.we0", w_we, 0);
        chk("sa.busy0", w_busy, 0);

        // back-to-back LW, SW, BR, JAL
        start_session("sb");
        xfer("lw",  3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 21'd8,        1'b0, 1'b1, 8'd0, 32'h00812283);
        xfer("sw",  3'd3, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 21'd12,       1'b0, 1'b1, 8'd1, 32'h00512623);
        xfer("beq", 3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFFC,   1'b0, 1'b1, 8'd2, 32'hFE208EE3);
        xfer("jal", 3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'h000800,   1'b1, 1'b1, 8'd3, 32'h001000EF);
        idle();
        chk("sb.done", w_done, 1);
        chk("sb.ww", w_ww, 4);
        step();
        chk("sb.done1", w_done, 0);

        // rejections, start during LOAD, sticky err
        start_session("sc");
        xfer("lwbig", 3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 21'd2048, 1'b0, 1'b0, 8'd0, 32'd0);
        chk("sc.err", w_err, 1);
        chk("sc.ww0", w_ww, 0);
        xfer("addi", 3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'h1FFFFF, 1'b0, 1'b1, 8'd0, 32'hFFF00093);
        r_m_start = 1'b1;
        xfer("srai", 3'd1, 3'd5, 1'b1, 5'd2, 5'd1, 5'd0, 21'd3, 1'b0, 1'b1, 8'd1, 32'h4030D113);
        r_m_start = 1'b0;
        xfer("brf3",  3'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 21'd8,      1'b0, 1'b0, 8'd0, 32'd0);
        xfer("brodd", 3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd3,      1'b0, 1'b0, 8'd0, 32'd0);
        xfer("brbig", 3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd4096,   1'b0, 1'b0, 8'd0, 32'd0);
        xfer("jalodd",3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd1,      1'b0, 1'b0, 8'd0, 32'd0);
        xfer("swneg", 3'd3, 3'd0, 1'b0, 5'd0, 5'd2, 5'd5, 21'h1FF7FF, 1'b0, 1'b0, 8'd0, 32'd0);
        xfer("jalr",  3'd6, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 21'd0,      1'b0, 1'b1, 8'd2, 32'h00008067);
        xfer("bne",   3'd4, 3'd1, 1'b0, 5'd0, 5'd3, 5'd4, 21'd8,      1'b0, 1'b1, 8'd3, 32'h00419463);
        xfer("kind7", 3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 21'd0,      1'b1, 1'b0, 8'd0, 32'd0);
        idle();
        chk("sc.done", w_done, 1);
        chk("sc.err1", w_err, 1);
        chk("sc.ww", w_ww, 4);
        step();
        chk("sc.done1", w_done, 0);
        chk("sc.errkeep", w_err, 1);

        // overflow on the 4-word instance
        r_sel = 1'b1;
        start_session("sd");
        for (int k = 0; k < 4; k++)
            xfer("ovw", 3'd0, 3'd0, 1'b0, 5'(k + 1), 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 8'(k),
                 32'h00208033 | (32'(k + 1) << 7));
        chk("sd.ovf", w_ovf, 1);
        chk("sd.done", w_done, 1);
        chk("sd.rdy0", w_ready, 0);
        chk("sd.ww", w_ww, 4);
        step();
        chk("sd.we5", w_we, 0);
        chk("sd.ww5", w_ww, 4);
        chk("sd.ovfkeep", w_ovf, 1);
        idle();
        start_session("sd2");
        xfer("ovrst", 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 8'd0, 32'h002081B3);
        idle();
        step();
        r_sel = 1'b0;

        // asynchronous reset while a write is on the bus
        start_session("se");
        xfer("serej", 3'd2, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 21'd2048, 1'b0, 1'b0, 8'd0, 32'd0);
        xfer("sewr",  3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0,    1'b0, 1'b1, 8'd0, 32'h002081B3);
        chk("se.err", w_err, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.we", m_we, 0);
        chk("ar.addr", m_addr, 0);
        chk("ar.data", m_wdata, 0);
        chk("ar.busy", m_busy, 0);
        chk("ar.ready", m_ready, 0);
        chk("ar.done", m_done, 0);
        chk("ar.err", m_err, 0);
        chk("ar.ww", m_ww, 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("ar.idle", m_done, 0);
        start_session("sf");
        xfer("sfadd", 3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b1, 1'b1, 8'd0, 32'h002081B3);
        idle();
        chk("sf.done", w_done, 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the opcode decoder/controller. Takes field-level instruction requests (kind, funct3, alt, rd, rs1, rs2, imm), builds RV32I instruction words and writes them sequentially into instruction memory through its write port.
- Used by the bench and boot path to load programs into the pipeline.
- Covers the same opcode set the controller decodes: R-type, I-ALU, LW, SW, branch, JAL and JALR.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a load session at word 0; ignored unless the FSM is in IDLE.
- req_valid  input  1  request present.
- req_ready  output  1  encoder can accept a request.
- req_last  input  1  request is the final one of the program.
- req_kind  input  3  0 R, 1 I-ALU, 2 LW, 3 SW, 4 BR, 5 JAL, 6 JALR, 7 illegal.
- req_funct3  input  3  funct3 for R, I-ALU and BR kinds.
- req_alt  input  1  R: funct7=0100000 (sub); I shifts: imm[11:5]=0100000 (srai).
- req_rd, req_rs1, req_rs2  input  5 each  register fields.
- req_imm  input  21  signed immediate or offset.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  FSM in LOAD.
- done  output  1  one-cycle pulse at session end.
- err  output  1  sticky: a request was rejected as unencodable.
- overflow  output  1  sticky: memory filled before req_last.
- words_written  output  ADDR_W+1  number of words written this session.

Behaviour:
- Reset values (applied asynchronously): FSM=IDLE, all outputs 0, address counter 0.
- FSM states and transitions:
  - IDLE: start → LOAD. Entering LOAD clears the address counter, words_written, err and overflow.
  - LOAD: req_ready=1. A transfer occurs when req_valid && req_ready.
  - DONE: done=1 for exactly one cycle, then the FSM returns to IDLE. start is ignored outside IDLE.
- Latency: a request accepted at edge N produces imem_we=1 with imem_addr and imem_wdata valid during cycle N+1. The registers hold for that one cycle only; imem_we is 0 otherwise.
- Throughput: one request per cycle, no bubbles.
- Encodings (opc = opcode):
  - R: {alt?0100000:0, rs2, rs1, f3, rd, 0110011}.
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}. For f3=001 or 101, bits [31:25] = alt?0100000:0 and bits [24:20] = imm[4:0].
  - LW: {imm[11:0], rs1, 010, rd, 0000011}.
  - SW: {imm[11:5], rs2, rs1, 010, imm[4:0], 0100011}.
  - BR: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
  - JALR: {imm[11:0], rs1, 000, rd, 1100111}.
  - Fields not used by a kind are ignored.
- Rejection rules:
  - I, LW, SW, JALR: imm must fit signed 12 bits (imm[20:11] all equal).
  - BR: imm must fit signed 13 bits and imm[0]=0.
  - JAL: imm[0]=0.
  - BR with f3 of 010 or 011 is rejected. kind=7 is rejected.
  - A rejected request is still accepted (handshake completes) but produces no write and does not advance the address. err is set and stays set until the next start.
  - req_last on a rejected request still ends the session.
- Address and full handling:
  - Each write increments the counter and words_written.
  - When the write goes to DEPTH-1 without req_last: overflow=1, req_ready drops in the following cycle, FSM → DONE.
  - The address never wraps.
- End of session: a transfer with req_last → DONE in the cycle after acceptance, coincident with the final imem_we. After that transfer, req_ready is 0.
- Reset mid-operation: state is abandoned immediately and imem_we drops asynchronously. A partial program stays in memory; no done pulse is issued.

Test Plan:
- start, then kind R, rd=3, rs1=1, rs2=2, f3=0 (add): expect imem_wdata=0x002081B3 at addr 0, one cycle after acceptance. Same with alt=1 (sub): 0x402081B3 at addr 1.
- LW rd=5, rs1=2, imm=8 → 0x00812283. SW rs2=5, rs1=2, imm=12 → 0x00512623. BR f3=0, rs1=1, rs2=2, imm=-4 → 0xFE208EE3. JAL rd=1, imm=2048 with req_last → 0x001000EF; then a done pulse and words_written=4.
- LW imm=2048 (out of range): no imem_we, err=1, address unchanged. Next valid request writes to the same address. err stays 1 until the next start.
- ADDR_W=2, 5 back-to-back requests with no req_last: 4 writes to addrs 0–3, overflow=1, done pulse, 5th request not accepted (req_ready=0).
- req_valid held high continuously over 3 requests: 3 consecutive imem_we cycles. start asserted during LOAD has no effect.
- Assert reset while imem_we=1 mid-session: all outputs 0 immediately, FSM in IDLE. A new start restarts at addr 0 with err and overflow cleared.
